// File: rtl/mult_acc_stage.sv
// Frame accumulator for the multiplier product stream: sums beats up to in_last into a saturating sum.
// Result valid the cycle after the last beat; upstream stalled (in_ready=0) while a result waits for out_ready.
module mult_acc_stage #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;
  logic             take_in;

  // Handshake outputs decode only the state register, so no input reaches them combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
  assign take_in   = in_valid & in_ready;

  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_prod};
    carry   = sum_ext[ACC_W];
    acc_upd = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    cnt_upd = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_upd = ovf_q | carry;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (take_in) begin
          if (in_last) begin
            // The closing beat lands in the result registers and the accumulator restarts clean.
            out_sum_d = acc_upd;
            out_cnt_d = cnt_upd;
            out_ovf_d = ovf_upd;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
            ovf_d = ovf_upd;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Bench for mult_acc_stage: table of constant-value frames, hand-written corner sequences,
// and random frames scored against a plain-arithmetic frame model.
module tb_mult_acc_stage;
  localparam int ACC_W = 12;
  localparam int CNT_W = 4;
  localparam int SUM_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_prod;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int total = 0;
  int bad   = 0;

  mult_acc_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int val;
    int e_sum;
    int e_cnt;
    int e_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the beat.
  task automatic send_beat(input int v, input logic l);
    in_valid = 1'b1;
    in_prod  = v[7:0];
    in_last  = l;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int delay, output int s, output int c, output int o);
    s = 0; c = 0; o = 0;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (out_valid) begin
        repeat (delay) @(negedge clk);
        s = int'(out_sum);
        c = int'(out_cnt);
        o = int'(out_ovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        return;
      end
    end
    check("result_timeout", 1, 0);
  endtask

  task automatic send_const_frame(input int n, input int v);
    for (int i = 0; i < n; i++) send_beat(v, (i == n - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int s, c, o;
    int vals[$];
    int ref_sum, ref_cnt, ref_ovf;

    tbl[0] = '{16, 225, 3600, 15, 0};
    tbl[1] = '{20, 255, 4095, 15, 1};
    tbl[2] = '{1,  1,   1,    1,  0};
    tbl[3] = '{1,  0,   0,    1,  0};
    tbl[4] = '{17, 240, 4080, 15, 0};
    tbl[5] = '{18, 240, 4095, 15, 1};
    tbl[6] = '{15, 1,   15,   15, 0};

    rst = 1'b1; in_prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    // Frame 3,5,7 with out_ready held high: one-cycle result pulse.
    out_ready = 1'b1;
    send_beat(3, 1'b0);
    send_beat(5, 1'b0);
    send_beat(7, 1'b1);
    @(negedge clk);
    check("f357_valid", out_valid, 1);
    check("f357_in_ready", in_ready, 0);
    check("f357_sum", out_sum, 15);
    check("f357_cnt", out_cnt, 3);
    check("f357_ovf", out_ovf, 0);
    @(negedge clk);
    check("f357_valid_drop", out_valid, 0);
    check("f357_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    foreach (tbl[i]) begin
      send_const_frame(tbl[i].n, tbl[i].val);
      get_result(0, s, c, o);
      check($sformatf("tbl%0d_sum", i), s, tbl[i].e_sum);
      check($sformatf("tbl%0d_cnt", i), c, tbl[i].e_cnt);
      check($sformatf("tbl%0d_ovf", i), o, tbl[i].e_ovf);
    end

    // After an overflowing frame the flag must not leak into the next one.
    send_const_frame(20, 255);
    get_result(0, s, c, o);
    check("ovf_frame_ovf", o, 1);
    send_beat(1, 1'b1);
    get_result(0, s, c, o);
    check("after_ovf_sum", s, 1);
    check("after_ovf_ovf", o, 0);

    // Back-pressure: result 42 held while a 99 waits upstream.
    send_beat(42, 1'b1);
    in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 42);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", out_valid, 1);
    check("bp_sum_kept", out_sum, 42);
    @(negedge clk);
    check("bp_taken", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("bp99_valid", out_valid, 1);
    check("bp99_sum", out_sum, 99);
    check("bp99_cnt", out_cnt, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset mid-frame discards the partial sum.
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    do_reset();
    send_beat(4, 1'b1);
    get_result(0, s, c, o);
    check("midrst_sum", s, 4);
    check("midrst_cnt", c, 1);
    check("midrst_ovf", o, 0);

    // Reset while holding an overflowed result.
    send_const_frame(20, 255);
    @(negedge clk);
    check("hold_valid", out_valid, 1);
    check("hold_ovf", out_ovf, 1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("holdrst_valid", out_valid, 0);
    check("holdrst_in_ready", in_ready, 1);
    check("holdrst_sum", out_sum, 0);
    check("holdrst_cnt", out_cnt, 0);
    check("holdrst_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    // Random frames against a whole-frame arithmetic model.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 24);
      vals.delete();
      for (int i = 0; i < n; i++)
        vals.push_back((f % 4 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255));
      ref_sum = 0;
      foreach (vals[i]) ref_sum += vals[i];
      ref_ovf = (ref_sum > SUM_MAX) ? 1 : 0;
      if (ref_sum > SUM_MAX) ref_sum = SUM_MAX;
      ref_cnt = (n > CNT_MAX) ? CNT_MAX : n;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_beat(vals[i], (i == n - 1));
      end
      get_result($urandom_range(0, 4), s, c, o);
      check($sformatf("rnd%0d_sum", f), s, ref_sum);
      check($sformatf("rnd%0d_cnt", f), c, ref_cnt);
      check($sformatf("rnd%0d_ovf", f), o, ref_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
